bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Parallel-in/serial-out stage that feeds the 1-bit din input of the FSM sequence detectors.
//  Accepts WIDTH-bit words on a valid/ready handshake and emits them MSB-first, one bit per clk.
//  Drives an idle fill level between frames and flags valid bits.
//  Back-to-back words are supported with zero gap cycles.
// PARAMETERS
//  WIDTH      8   bits per word (>=2)
//  IDLE_FILL  0   level driven on dout while no frame bit is active
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  in_data      in   WIDTH  parallel word; sampled on an accepted transfer
//  in_valid     in   1      in_data is valid
//  in_ready     out  1      block can accept a word this cycle
//  dout         out  1      serial bit; connects to detector din
//  dout_valid   out  1      dout carries a frame bit (data or parity)
//  frame_start  out  1      high while the first (MSB) bit of a frame is on dout
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset values: state IDLE; sreg 0; cnt 0; dout=IDLE_FILL; dout_valid=0; frame_start=0; busy=0.
//    in_ready is forced 0 while rst=1.
//  - Accept = in_valid & in_ready at a clk edge.
//    On accept: sreg<=in_data; cnt<=WIDTH-1; state<=SHIFT.
//  - Latency: a word accepted at edge N puts its MSB on dout in cycle N+1.
//    All outputs are driven from registers/state only; there is no comb path from in_* to dout.
//  - FSM states IDLE, SHIFT (plus PAR when the optional feature is enabled):
//    IDLE : dout=IDLE_FILL, dout_valid=0, in_ready=1. Accept moves to SHIFT.
//    SHIFT: dout=sreg[WIDTH-1], dout_valid=1. Each cycle: sreg<<=1 (zero-fill), cnt-=1.
//           While cnt!=0: in_ready=0.
//           When cnt==0 (last data bit):
//             without parity: in_ready=1; accept stays in SHIFT with the new word, else go to IDLE.
//             with parity: in_ready=0; go to PAR.
//  - frame_start=1 exactly in the first SHIFT cycle after each accept, including back-to-back frames.
//  - in_valid held low during a frame has no effect. in_data may change while in_ready=0.
//  - cnt width is $clog2(WIDTH). cnt never wraps: it is reloaded on accept, never decremented below 0.
//  - Reset mid-frame: the frame is aborted and the remaining bits are discarded.
//    The next cycle shows IDLE outputs. The aborted word is never replayed.
//  - Simultaneous rst and accept: rst wins; the word is not taken.
// CONFIGURATION
//  SER_PARITY_EN defined:
//   - An even-parity bit (^word) follows the LSB as a (WIDTH+1)-th bit, in state PAR.
//   - In PAR: dout=parity, dout_valid=1, in_ready=1. Accept goes to SHIFT with no gap; else IDLE.
//   - Parity is registered at accept time.
//  SER_PARITY_EN undefined: there is no PAR state and no parity register; frames are WIDTH bits.
// STRUCTURE
//  - seq_pkg: state typedef ser_state_t {IDLE, SHIFT, PAR} and the shared IDLE_FILL default constant.
//  - Sub-module ser_shift_reg: load/shift register with MSB tap, WIDTH-parameterised.
//    Used by this block and reusable by later detector benches.
//  - The top level holds the FSM, the counter and the handshake.
// TESTING
//  1. Reset, then send 8'hD0 once -> dout=1,1,0,1,0,0,0,0 in cycles 1-8.
//     dout_valid high for exactly 8 cycles; frame_start only in cycle 1; then dout=IDLE_FILL.
//  2. Send 8'hAA then 8'h55 with in_valid held -> 16 contiguous valid bits 10101010_01010101.
//     in_ready high only in the last-bit cycle of the first word; two frame_start pulses, 8 apart.
//  3. Backpressure: raise in_valid with 8'h3C mid-frame and change in_data before last bit ->
//     the word present at the cnt==0 edge is taken; no bit loss or duplication.
//  4. Assert rst during bit 3 of 8'hFF -> next cycle dout_valid=0, dout=IDLE_FILL, in_ready=1.
//     The remaining five 1s never appear.
//  5. SER_PARITY_EN, send 8'hD0 -> 9th bit=1; send 8'hC0 -> 9th bit=0.
//     Back-to-back frames stay gapless (18 valid cycles).
//  6. WIDTH=4 feeding the 1101 detector: send 4'b1101,4'b1011 ->
//     detector dout pulses twice (once per 1101, overlap case included), IDLE_FILL=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial front-end that feeds the sequence detectors.
// The optional parity stage is enabled with the SER_PARITY_EN macro (see bit_serializer.sv).
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_t;

  localparam logic IDLE_FILL_DEFAULT = 1'b0;

endpackage

// File: rtl/ser_shift_reg.sv
// Load/shift register with an MSB tap; shifts left with zero fill.
// Load has priority over shift so a back-to-back word replaces the spent one cleanly.
module ser_shift_reg
  import seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] sreg_r;

  // shift register: reset, load, shift or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sreg_r <= load_data;
    end else if (shift) begin
      sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
    end else begin
      sreg_r <= sreg_r;
    end
  end

  assign msb = sreg_r[WIDTH-1];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage: WIDTH-bit words on valid/ready, emitted MSB-first one bit per clk.
// Define SER_PARITY_EN to append an even-parity bit after the LSB of every frame.
module bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter logic IDLE_FILL = IDLE_FILL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  ser_state_t       state_r;
  ser_state_t       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             frame_start_r;
  logic             ready_s;
  logic             accept_s;
  logic             last_bit_s;
  logic             shift_s;
  logic             msb_s;
  logic             dout_s;
  logic             dout_valid_s;

`ifdef SER_PARITY_EN
  logic parity_r;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  // parity is captured with the word so later in_data changes cannot affect it
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else if (accept_s) begin
      parity_r <= even_parity(in_data);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  assign accept_s   = in_valid & in_ready;
  assign last_bit_s = (state_r == SHIFT) && (cnt_r == CNT_ZERO);
  assign shift_s    = (state_r == SHIFT);

  ser_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_s),
    .shift     (shift_s),
    .load_data (in_data),
    .msb       (msb_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r != CNT_ZERO) begin
          next_state_s = SHIFT;
        end else begin
`ifdef SER_PARITY_EN
          next_state_s = PAR;
`else
          next_state_s = accept_s ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        if (accept_s) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
`endif
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // output logic; only state and registers feed dout, never the in_* ports
  always_comb begin
    dout_s       = IDLE_FILL;
    dout_valid_s = 1'b0;
    ready_s      = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
      end
      SHIFT: begin
        dout_s       = msb_s;
        dout_valid_s = 1'b1;
`ifdef SER_PARITY_EN
        ready_s      = 1'b0;
`else
        ready_s      = last_bit_s;
`endif
      end
`ifdef SER_PARITY_EN
      PAR: begin
        dout_s       = parity_r;
        dout_valid_s = 1'b1;
        ready_s      = 1'b1;
      end
`endif
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // bit counter: reloaded on accept, stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      cnt_r <= CNT_LAST;
    end else if ((state_r == SHIFT) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // frame_start marks the first SHIFT cycle after every accept
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= accept_s;
    end
  end

  assign in_ready    = ready_s & ~rst;
  assign dout        = dout_s;
  assign dout_valid  = dout_valid_s;
  assign frame_start = frame_start_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: a scoreboard queue of expected bits filled on accept,
// drained as dout_valid bits appear; a WIDTH=4 instance feeds a bench-side 1101 detector.
module tb_bit_serializer;

  localparam int   W    = 8;
  localparam logic FILL = 1'b0;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } ent_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         dout;
  logic         dout_valid;
  logic         frame_start;
  logic         busy;

  logic [3:0] in_data4;
  logic       in_valid4;
  logic       in_ready4;
  logic       dout4;
  logic       dout_valid4;
  logic       frame_start4;
  logic       busy4;

  ent_t q[$];
  int   total;
  int   bad;

  bit_serializer #(.WIDTH(W), .IDLE_FILL(FILL)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  bit_serializer #(.WIDTH(4), .IDLE_FILL(1'b0)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data4),
    .in_valid    (in_valid4),
    .in_ready    (in_ready4),
    .dout        (dout4),
    .dout_valid  (dout_valid4),
    .frame_start (frame_start4),
    .busy        (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    ent_t e;
    logic par;
    par = ^w;
    for (int i = W - 1; i >= 0; i--) begin
      e.b     = w[i];
      e.first = (i == W - 1);
`ifdef SER_PARITY_EN
      e.last  = 1'b0;
`else
      e.last  = (i == 0);
`endif
      q.push_back(e);
    end
`ifdef SER_PARITY_EN
    e.b     = par;
    e.first = 1'b0;
    e.last  = 1'b1;
    q.push_back(e);
`endif
  endtask

  task automatic check_outputs();
    ent_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk1("dout", dout, e.b);
      chk1("dout_valid", dout_valid, 1'b1);
      chk1("frame_start", frame_start, e.first);
      chk1("in_ready", in_ready, rst ? 1'b0 : e.last);
      chk1("busy", busy, 1'b1);
    end else begin
      chk1("idle_dout", dout, FILL);
      chk1("idle_dout_valid", dout_valid, 1'b0);
      chk1("idle_frame_start", frame_start, 1'b0);
      chk1("idle_in_ready", in_ready, rst ? 1'b0 : 1'b1);
      chk1("idle_busy", busy, 1'b0);
    end
  endtask

  // one clock: inputs are already set; record an accept, cross the edge, check at negedge
  task automatic tick(output bit acc);
    #1;
    acc = 1'b0;
    if (rst) begin
      q.delete();
    end else if (in_valid && in_ready) begin
      acc = 1'b1;
      push_word(in_data);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    bit acc;
    acc = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(acc);
      if (acc) break;
    end
    in_valid = 1'b0;
    chk1("accept_timeout", acc, 1'b1);
  endtask

  initial begin
    bit         acc;
    int         n4;
    int         nbits;
    int         det;
    logic [7:0] stream;
    logic [3:0] hist;

    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_data4  = 4'h0;
    in_valid4 = 1'b0;
    @(negedge clk);
    ticks(2);
    rst = 1'b0;
    ticks(2);

    // single frame D0
    send_word(8'hD0);
    ticks(10);

    // back-to-back AA then 55
    send_word(8'hAA);
    send_word(8'h55);
    ticks(10);

    // backpressure: word offered mid-frame, data changed before the last bit
    send_word(8'h81);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    ticks(3);
    in_data = 8'hE7;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    chk1("bp_accept", acc, 1'b1);
    in_valid = 1'b0;
    ticks(12);

    // reset during bit 3 of FF
    send_word(8'hFF);
    ticks(2);
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    ticks(8);

    // reset and a valid word together: reset wins
    in_data  = 8'hAB;
    in_valid = 1'b1;
    rst      = 1'b1;
    ticks(1);
    in_valid = 1'b0;
    rst      = 1'b0;
    ticks(3);

    // parity-sensitive pair, back-to-back
    send_word(8'hD0);
    send_word(8'hC0);
    ticks(12);

    // WIDTH=4 into a 1101 detector model
    n4     = 0;
    nbits  = 0;
    det    = 0;
    stream = 8'h00;
    hist   = 4'h0;
    in_data4  = 4'b1101;
    in_valid4 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (in_valid4 && in_ready4) n4++;
      @(posedge clk);
      @(negedge clk);
      if (dout_valid4) begin
        stream = {stream[6:0], dout4};
        hist   = {hist[2:0], dout4};
        nbits++;
        if (nbits >= 4 && hist == 4'b1101) det++;
      end
      if (n4 == 1) in_data4 = 4'b1011;
      if (n4 >= 2) in_valid4 = 1'b0;
    end
    chkw("w4_accepts", n4, 32'd2);
`ifdef SER_PARITY_EN
    chkw("w4_bits", nbits, 32'd10);
`else
    chkw("w4_bits", nbits, 32'd8);
    chkw("w4_stream", {24'h0, stream}, 32'h0000_00DB);
    chkw("w4_detects", det, 32'd2);
`endif
    chk1("w4_idle_dout", dout4, 1'b0);

    chkw("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
